// File: rtl/adc_serial_readout_if.sv
// Core-facing bundle of the ADC readout block: control, ADC pins and the word stream.
// slave = the readout controller, master = whatever drives and consumes it.
interface adc_serial_readout_if;
   logic        START;
   logic        CONTINUOUS;
   logic [3:0]  CH_EN;
   logic        BUSY;
   logic [1:0]  ADC_CLK_OUT;
   logic [3:0]  ADC_CS_OUT;
   logic [31:0] ADC_DATA_IN;
   logic        DOUT_VALID;
   logic        DOUT_READY;
   logic [4:0]  DOUT_CH;
   logic [15:0] DOUT_DATA;
   logic [15:0] CONV_COUNT;

   modport slave (
      input  START, CONTINUOUS, CH_EN, ADC_DATA_IN, DOUT_READY,
      output BUSY, ADC_CLK_OUT, ADC_CS_OUT, DOUT_VALID, DOUT_CH, DOUT_DATA, CONV_COUNT
   );

   modport master (
      output START, CONTINUOUS, CH_EN, ADC_DATA_IN, DOUT_READY,
      input  BUSY, ADC_CLK_OUT, ADC_CS_OUT, DOUT_VALID, DOUT_CH, DOUT_DATA, CONV_COUNT
   );
endinterface

// File: rtl/adc_serial_readout.sv
// Serial readout of 32 ADC lines: drives ADC clocks/CS, captures NBITS per line, streams words.
// Latency: CLK_DIV*(1+2*NBITS) CS-low + QUIET_CYCLES, then one word per cycle while ready.
// Backpressure: DOUT_READY low holds the current word and keeps the ADC idle until drained.
module adc_serial_readout #(
   parameter int CLK_DIV      = 2,
   parameter int NBITS        = 16,
   parameter int QUIET_CYCLES = 4
) (
   input logic                  CLK,
   input logic                  RST_N,
   adc_serial_readout_if.slave  bus
);
   localparam int CW = 16;

   typedef enum logic [2:0] {IDLE, CS_SETUP, SHIFT, QUIET, DRAIN} state_t;
   state_t state, state_nxt;

   logic [CW-1:0]    cnt;
   logic             half;      // 0 = serial clock low phase
   logic [4:0]       bit_cnt;
   logic [3:0]       en_q;
   logic [4:0]       ch;
   logic [15:0]      conv_cnt;
   logic [NBITS-1:0] shreg [32];

   logic       div_end, quiet_end, xfer, last_word, restart, has_next;
   logic [1:0] first_grp, next_grp;

   assign div_end   = (cnt == CW'(CLK_DIV - 1));
   assign quiet_end = (cnt == CW'(QUIET_CYCLES - 1));
   assign xfer      = (state == DRAIN) && bus.DOUT_READY;
   assign last_word = (ch[2:0] == 3'd7) && !has_next;
   assign restart   = bus.CONTINUOUS && (bus.CH_EN != 4'h0);

   // Drain only visits enabled groups, so the last transfer is known on its own edge.
   always_comb begin
      first_grp = '0;
      next_grp  = '0;
      has_next  = 1'b0;
      for (int g = 3; g >= 0; g--) begin
         if (en_q[g]) first_grp = 2'(g);
         if (en_q[g] && (g > int'(ch[4:3]))) begin
            next_grp = 2'(g);
            has_next = 1'b1;
         end
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt       = state;
      bus.BUSY        = (state != IDLE);
      bus.ADC_CS_OUT  = 4'hF;
      bus.ADC_CLK_OUT = 2'b11;
      bus.DOUT_VALID  = 1'b0;
      bus.DOUT_CH     = '0;
      bus.DOUT_DATA   = '0;
      bus.CONV_COUNT  = conv_cnt;
      case (state)
         IDLE:     if (bus.START && (bus.CH_EN != 4'h0)) state_nxt = CS_SETUP;
         CS_SETUP: begin
            bus.ADC_CS_OUT = ~en_q;
            if (div_end) state_nxt = SHIFT;
         end
         SHIFT: begin
            bus.ADC_CS_OUT = ~en_q;
            for (int k = 0; k < 2; k++)
               if (en_q[2*k] || en_q[2*k+1]) bus.ADC_CLK_OUT[k] = half;
            if (div_end && half && (bit_cnt == 5'(NBITS - 1))) state_nxt = QUIET;
         end
         QUIET:    if (quiet_end) state_nxt = DRAIN;
         DRAIN: begin
            bus.DOUT_VALID = 1'b1;
            bus.DOUT_CH    = ch;
            bus.DOUT_DATA  = 16'(shreg[ch]);
            if (xfer && last_word) state_nxt = restart ? CS_SETUP : IDLE;
         end
         default:  state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         cnt      <= '0;
         half     <= 1'b0;
         bit_cnt  <= '0;
         en_q     <= '0;
         ch       <= '0;
         conv_cnt <= '0;
         for (int n = 0; n < 32; n++) shreg[n] <= '0;
      end else begin
         case (state)
            IDLE: begin
               cnt <= '0;
               if (bus.START && (bus.CH_EN != 4'h0)) en_q <= bus.CH_EN;
            end
            CS_SETUP: begin
               cnt     <= div_end ? '0 : cnt + 1'b1;
               half    <= 1'b0;
               bit_cnt <= '0;
            end
            SHIFT: begin
               cnt <= div_end ? '0 : cnt + 1'b1;
               if (div_end) begin
                  half <= ~half;
                  if (!half) begin
                     for (int n = 0; n < 32; n++)
                        shreg[n] <= {shreg[n][NBITS-2:0], bus.ADC_DATA_IN[n]};
                  end else if (bit_cnt == 5'(NBITS - 1)) begin
                     conv_cnt <= conv_cnt + 16'd1;
                  end else begin
                     bit_cnt <= bit_cnt + 5'd1;
                  end
               end
            end
            QUIET: begin
               cnt <= quiet_end ? '0 : cnt + 1'b1;
               if (quiet_end) ch <= {first_grp, 3'b000};
            end
            DRAIN: begin
               if (xfer) begin
                  if (last_word) begin
                     ch  <= '0;
                     cnt <= '0;
                     if (restart) en_q <= bus.CH_EN;
                  end else if (ch[2:0] == 3'd7) begin
                     ch <= {next_grp, 3'b000};
                  end else begin
                     ch <= ch + 5'd1;
                  end
               end
            end
            default: cnt <= '0;
         endcase
      end
   end
endmodule

// File: tb/tb_adc_serial_readout.sv
// Randomized bench for adc_serial_readout: timeline-based reference model plus directed literal checks.
module tb_adc_serial_readout;
   localparam int CLK_DIV = 2;
   localparam int NB      = 16;
   localparam int Q       = 4;
   localparam int CSLOW   = CLK_DIV * (1 + 2 * NB);

   logic CLK = 1'b0;
   logic RST_N = 1'b0;
   always #5 CLK = ~CLK;

   adc_serial_readout_if bus();
   adc_serial_readout_if bus12();

   adc_serial_readout #(.CLK_DIV(CLK_DIV), .NBITS(NB), .QUIET_CYCLES(Q)) dut (
      .CLK(CLK), .RST_N(RST_N), .bus(bus));
   adc_serial_readout #(.CLK_DIV(2), .NBITS(12), .QUIET_CYCLES(4)) dut12 (
      .CLK(CLK), .RST_N(RST_N), .bus(bus12));

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // ---------------- ADC line model (main DUT) ----------------
   logic [15:0] words [32];
   bit          use_pattern = 1'b0;
   int          bidx [4];
   logic [1:0]  clk_prev = 2'b11;

   always @(posedge CLK) begin
      #1;
      for (int g = 0; g < 4; g++) begin
         if (bus.ADC_CS_OUT[g]) bidx[g] = 0;
         else if (bus.ADC_CLK_OUT[g/2] && !clk_prev[g/2]) bidx[g]++;
      end
      clk_prev = bus.ADC_CLK_OUT;
      for (int n = 0; n < 32; n++)
         bus.ADC_DATA_IN[n] = (bidx[n/8] < NB) ? words[n][NB-1-bidx[n/8]] : 1'b0;
   end

   // ---------------- reference model + per-cycle compare ----------------
   bit          m_busy = 1'b0, m_drain = 1'b0;
   logic [3:0]  m_en = '0;
   int          t = 0;
   logic [15:0] m_count = '0;
   logic [20:0] expq [$];
   logic [20:0] xlog [$];

   task automatic new_words();
      for (int n = 0; n < 32; n++)
         words[n] = use_pattern ? 16'(16'h1000 + n) : 16'($urandom);
   endtask

   always @(negedge CLK) begin : monitor
      logic [3:0] exp_cs;
      logic [1:0] exp_clk;
      int r;
      if (!RST_N) begin
         m_busy = 1'b0;
         m_drain = 1'b0;
         m_count = '0;
         expq.delete();
      end else begin
         exp_cs  = 4'hF;
         exp_clk = 2'b11;
         if (m_busy && !m_drain) begin
            if (t < CSLOW) exp_cs = ~m_en;
            r = t - CLK_DIV;
            if (r >= 0 && r < 2 * CLK_DIV * NB)
               for (int k = 0; k < 2; k++)
                  if (m_en[2*k] || m_en[2*k+1]) exp_clk[k] = ((r % (2 * CLK_DIV)) >= CLK_DIV);
         end
         chk("busy", bus.BUSY, m_busy);
         chk("cs", bus.ADC_CS_OUT, exp_cs);
         chk("adc_clk", bus.ADC_CLK_OUT, exp_clk);
         chk("valid", bus.DOUT_VALID, m_busy && m_drain);
         chk("conv_count", bus.CONV_COUNT, m_count);
         if (m_busy && m_drain && expq.size() > 0) begin
            chk("dout_ch", bus.DOUT_CH, expq[0][20:16]);
            chk("dout_data", bus.DOUT_DATA, expq[0][15:0]);
         end
         if (bus.DOUT_VALID && bus.DOUT_READY) xlog.push_back({bus.DOUT_CH, bus.DOUT_DATA});
         // advance the model to the next cycle
         if (!m_busy) begin
            if (bus.START && bus.CH_EN != 4'h0) begin
               m_busy = 1'b1; m_en = bus.CH_EN; t = 0; m_drain = 1'b0; new_words();
            end
         end else if (!m_drain) begin
            t++;
            if (t == CSLOW) m_count++;
            if (t == CSLOW + Q) begin
               m_drain = 1'b1;
               for (int n = 0; n < 32; n++)
                  if (m_en[n/8]) expq.push_back({5'(n), words[n]});
            end
         end else if (bus.DOUT_READY) begin
            void'(expq.pop_front());
            if (expq.size() == 0) begin
               if (bus.CONTINUOUS && bus.CH_EN != 4'h0) begin
                  m_en = bus.CH_EN; t = 0; m_drain = 1'b0; new_words();
               end else begin
                  m_busy = 1'b0; m_drain = 1'b0;
               end
            end
         end
      end
   end

   // ---------------- activity counters ----------------
   int         cs_low_grp [4];
   int         rises [2];
   int         min_gap = 1000000, gap_run = 0;
   bit         seen_low = 1'b0;
   logic [1:0] pclk = 2'b11;

   always @(negedge CLK) begin
      for (int g = 0; g < 4; g++) if (!bus.ADC_CS_OUT[g]) cs_low_grp[g]++;
      for (int k = 0; k < 2; k++) if (bus.ADC_CLK_OUT[k] && !pclk[k]) rises[k]++;
      pclk = bus.ADC_CLK_OUT;
      if (bus.ADC_CS_OUT == 4'hF) gap_run++;
      else begin
         if (seen_low && gap_run > 0 && gap_run < min_gap) min_gap = gap_run;
         seen_low = 1'b1;
         gap_run = 0;
      end
   end

   task automatic clear_stats();
      for (int g = 0; g < 4; g++) cs_low_grp[g] = 0;
      rises[0] = 0; rises[1] = 0;
      min_gap = 1000000; gap_run = 0; seen_low = 1'b0;
      xlog.delete();
   endtask

   // ---------------- NBITS=12 instance ----------------
   logic [11:0] pat12 = 12'hABC;
   int          bidx12 = 0, cs12 = 0, rise12 = 0, words12 = 0;
   logic [15:0] data12 = '0;
   logic        pclk12 = 1'b1, nclk12 = 1'b1;

   always @(posedge CLK) begin
      #1;
      if (bus12.ADC_CS_OUT[0]) bidx12 = 0;
      else if (bus12.ADC_CLK_OUT[0] && !pclk12) bidx12++;
      pclk12 = bus12.ADC_CLK_OUT[0];
      bus12.ADC_DATA_IN = (bidx12 < 12) ? {32{pat12[11-bidx12]}} : 32'h0;
   end

   always @(negedge CLK) begin
      if (!bus12.ADC_CS_OUT[0]) cs12++;
      if (bus12.ADC_CLK_OUT[0] && !nclk12) rise12++;
      nclk12 = bus12.ADC_CLK_OUT[0];
      if (bus12.DOUT_VALID && bus12.DOUT_READY) begin
         if (words12 == 0) data12 = bus12.DOUT_DATA;
         words12++;
      end
   end

   // ---------------- stimulus ----------------
   task automatic pulse_start(input logic [3:0] en);
      bus.CH_EN = en;
      bus.START = 1'b1;
      tick();
      bus.START = 1'b0;
   endtask

   task automatic wait_idle(input string name, input int budget);
      int n = 0;
      while (bus.BUSY && n < budget) begin tick(); n++; end
      chk(name, bus.BUSY, 1'b0);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_clk"}, bus.ADC_CLK_OUT, 2'b11);
      chk({tag, "_cs"}, bus.ADC_CS_OUT, 4'hF);
      chk({tag, "_busy"}, bus.BUSY, 1'b0);
      chk({tag, "_valid"}, bus.DOUT_VALID, 1'b0);
      chk({tag, "_ch"}, bus.DOUT_CH, 5'd0);
      chk({tag, "_data"}, bus.DOUT_DATA, 16'h0);
      chk({tag, "_count"}, bus.CONV_COUNT, 16'h0);
   endtask

   initial begin : watchdog
      #600000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [15:0] c0, d2;
      int n;
      bus.START = 0; bus.CONTINUOUS = 0; bus.CH_EN = 0; bus.DOUT_READY = 1;
      bus12.START = 0; bus12.CONTINUOUS = 0; bus12.CH_EN = 0; bus12.DOUT_READY = 1;
      for (int i = 0; i < 32; i++) words[i] = '0;
      repeat (3) tick();
      chk_reset_vals("reset");
      RST_N = 1'b1;
      tick();

      // single conversion, fixed pattern, all groups
      use_pattern = 1'b1;
      clear_stats();
      pulse_start(4'hF);
      wait_idle("t1_idle", 400);
      chk("t1_cs_low", cs_low_grp[0], 66);
      chk("t1_cs3_low", cs_low_grp[3], 66);
      chk("t1_rise0", rises[0], 16);
      chk("t1_rise1", rises[1], 16);
      chk("t1_nwords", xlog.size(), 32);
      if (xlog.size() == 32) begin
         chk("t1_w0", xlog[0], {5'd0, 16'h1000});
         chk("t1_w17", xlog[17], {5'd17, 16'h1011});
         chk("t1_w31", xlog[31], {5'd31, 16'h101F});
      end
      chk("t1_count", bus.CONV_COUNT, 16'd1);

      // group 2 only
      use_pattern = 1'b0;
      clear_stats();
      pulse_start(4'b0100);
      wait_idle("t2_idle", 400);
      chk("t2_cs2_low", cs_low_grp[2], 66);
      chk("t2_cs0_low", cs_low_grp[0], 0);
      chk("t2_rise0", rises[0], 0);
      chk("t2_rise1", rises[1], 16);
      chk("t2_nwords", xlog.size(), 8);
      if (xlog.size() == 8) begin
         chk("t2_first_ch", xlog[0][20:16], 5'd16);
         chk("t2_last_ch", xlog[7][20:16], 5'd23);
      end

      // backpressure on the third word
      clear_stats();
      pulse_start(4'hF);
      n = 0;
      while (!(bus.DOUT_VALID && bus.DOUT_CH == 5'd2) && n < 300) begin tick(); n++; end
      chk("bp_reach_ch2", bus.DOUT_CH, 5'd2);
      d2 = bus.DOUT_DATA;
      bus.DOUT_READY = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("bp_valid_held", bus.DOUT_VALID, 1'b1);
         chk("bp_ch_held", bus.DOUT_CH, 5'd2);
         chk("bp_data_held", bus.DOUT_DATA, d2);
         chk("bp_cs_idle", bus.ADC_CS_OUT, 4'hF);
      end
      bus.DOUT_READY = 1'b1;
      wait_idle("bp_idle", 200);
      chk("bp_nwords", xlog.size(), 32);

      // continuous, 3 conversions, START pulses while busy
      clear_stats();
      c0 = bus.CONV_COUNT;
      bus.CONTINUOUS = 1'b1;
      pulse_start(4'hF);
      n = 0;
      while (bus.CONV_COUNT != 16'(c0 + 16'd3) && n < 1000) begin
         bus.START = ((n % 40) == 5);
         tick();
         n++;
      end
      bus.START = 1'b0;
      bus.CONTINUOUS = 1'b0;
      wait_idle("cont_idle", 300);
      chk("cont_count", 16'(bus.CONV_COUNT - c0), 16'd3);
      chk("cont_gap_ok", (min_gap >= Q + 32), 1'b1);
      chk("cont_nwords", xlog.size(), 96);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         bus.DOUT_READY = ($urandom_range(0, 3) != 0);
         bus.START      = ($urandom_range(0, 15) == 0);
         bus.CH_EN      = 4'($urandom);
         bus.CONTINUOUS = ($urandom_range(0, 5) == 0);
         tick();
      end
      bus.START = 1'b0; bus.CONTINUOUS = 1'b0; bus.DOUT_READY = 1'b1;
      wait_idle("rand_idle", 500);

      // asynchronous reset during bit 7
      pulse_start(4'hF);
      repeat (CLK_DIV + 2 * CLK_DIV * 7) tick();
      chk("rst_busy_before", bus.BUSY, 1'b1);
      @(negedge CLK);
      #2 RST_N = 1'b0;
      #1 chk_reset_vals("async_rst");
      repeat (2) tick();
      RST_N = 1'b1;
      tick();
      use_pattern = 1'b1;
      clear_stats();
      pulse_start(4'hF);
      wait_idle("rst_idle", 400);
      chk("rst_nwords", xlog.size(), 32);
      if (xlog.size() == 32) chk("rst_w5", xlog[5], {5'd5, 16'h1005});
      chk("rst_count", bus.CONV_COUNT, 16'd1);

      // NBITS=12 instance
      cs12 = 0; rise12 = 0; words12 = 0;
      bus12.CH_EN = 4'b0001;
      bus12.START = 1'b1;
      tick();
      bus12.START = 1'b0;
      n = 0;
      while (bus12.BUSY && n < 400) begin tick(); n++; end
      chk("n12_idle", bus12.BUSY, 1'b0);
      chk("n12_cs_low", cs12, 50);
      chk("n12_rise", rise12, 12);
      chk("n12_nwords", words12, 8);
      chk("n12_data", data12, 16'h0ABC);
      chk("n12_count", bus12.CONV_COUNT, 16'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
